// File: rtl/mem_port_arbiter.sv
// Shares one SRAM-like memory port between the IF (inst) and MEM (data) requesters, one transaction in flight.
// Optional macro ARB_FAIR_EN: bounds how long a pending inst request can be starved by data grants.
module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                inst_req,
    input  logic [ADDR_W-1:0]   inst_addr,
    output logic                inst_addr_ok,
    output logic                inst_data_ok,
    output logic [DATA_W-1:0]   inst_rdata,
    input  logic                data_req,
    input  logic                data_wr,
    input  logic [DATA_W/8-1:0] data_wstrb,
    input  logic [ADDR_W-1:0]   data_addr,
    input  logic [DATA_W-1:0]   data_wdata,
    output logic                data_addr_ok,
    output logic                data_data_ok,
    output logic [DATA_W-1:0]   data_rdata,
    output logic                mem_req,
    output logic                mem_wr,
    output logic [DATA_W/8-1:0] mem_wstrb,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic                mem_addr_ok,
    input  logic                mem_data_ok,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                busy,
    output logic                proto_err
);
    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2} state_t;

    state_t              state_q;
    logic                owner_q;
    logic                mem_req_q;
    logic                mem_wr_q;
    logic [DATA_W/8-1:0] mem_wstrb_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [DATA_W-1:0]   mem_wdata_q;
    logic                proto_err_q;
    logic                grant_inst;
    logic                grant_data;
    logic                rsp_fire;
    logic                inst_turn;

    // The starvation counter is only 3 bits wide, so a larger limit could never be reached.
    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 7) begin : g_bad_limit
        $error("STARVE_LIMIT must be in 1..7");
    end

`ifdef ARB_FAIR_EN
    localparam logic [2:0] STARVE_MAX = 3'(STARVE_LIMIT);
    logic [2:0] starve_q;

    assign inst_turn = (starve_q == STARVE_MAX);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_q <= '0;
        end else if (grant_inst) begin
            starve_q <= '0;
        end else if (grant_data && inst_req && starve_q != 3'd7) begin
            starve_q <= starve_q + 3'd1;
        end
    end
`else
    assign inst_turn = 1'b0;
`endif

    always_comb begin
        grant_inst = 1'b0;
        grant_data = 1'b0;
        if (state_q == IDLE && !reset) begin
            if (data_req && !(inst_req && inst_turn)) begin
                grant_data = 1'b1;
            end else if (inst_req) begin
                grant_inst = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            owner_q     <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_wstrb_q <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            proto_err_q <= 1'b0;
        end else begin
            if (mem_data_ok && state_q != WAIT) begin
                proto_err_q <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (grant_data || grant_inst) begin
                        owner_q     <= grant_data;
                        mem_req_q   <= 1'b1;
                        mem_addr_q  <= grant_data ? data_addr : inst_addr;
                        mem_wr_q    <= grant_data & data_wr;
                        mem_wstrb_q <= (grant_data && data_wr) ? data_wstrb : '0;
                        mem_wdata_q <= grant_data ? data_wdata : '0;
                        state_q     <= REQ;
                    end
                end
                REQ: begin
                    if (mem_addr_ok) begin
                        mem_req_q <= 1'b0;
                        state_q   <= WAIT;
                    end
                end
                WAIT: begin
                    if (mem_data_ok) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Responses are forwarded combinationally so the owner sees data in the completion cycle.
    assign rsp_fire     = (state_q == WAIT) && mem_data_ok && !reset;
    assign inst_addr_ok = grant_inst;
    assign data_addr_ok = grant_data;
    assign inst_data_ok = rsp_fire && !owner_q;
    assign data_data_ok = rsp_fire && owner_q;
    assign inst_rdata   = owner_q ? '0 : mem_rdata;
    assign data_rdata   = owner_q ? mem_rdata : '0;

    assign mem_req   = mem_req_q;
    assign mem_wr    = mem_wr_q;
    assign mem_wstrb = mem_wstrb_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = (state_q != IDLE);
    assign proto_err = proto_err_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: grant/response expectations are queued by the stimulus
// and popped by an independent monitor; a small memory responder supplies wait states.
module tb_mem_port_arbiter;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    typedef struct packed {
        logic        owner;
        logic [31:0] rdata;
    } dexp_t;

    logic              clk = 1'b0;
    logic              reset;
    logic              inst_req;
    logic [ADDR_W-1:0] inst_addr;
    logic              inst_addr_ok;
    logic              inst_data_ok;
    logic [DATA_W-1:0] inst_rdata;
    logic              data_req;
    logic              data_wr;
    logic [3:0]        data_wstrb;
    logic [ADDR_W-1:0] data_addr;
    logic [DATA_W-1:0] data_wdata;
    logic              data_addr_ok;
    logic              data_data_ok;
    logic [DATA_W-1:0] data_rdata;
    logic              mem_req;
    logic              mem_wr;
    logic [3:0]        mem_wstrb;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_addr_ok;
    logic              mem_data_ok;
    logic [DATA_W-1:0] mem_rdata;
    logic              busy;
    logic              proto_err;

    bit                resp_en;
    logic              auto_aok, auto_dok, man_aok, man_dok;
    logic [DATA_W-1:0] auto_rdata;
    int                addr_dly, data_dly;
    int                checks = 0;
    int                failures = 0;

    bit          gq[$];
    dexp_t       dq[$];
    logic [31:0] rq[$];

    assign mem_addr_ok = resp_en ? auto_aok : man_aok;
    assign mem_data_ok = resp_en ? auto_dok : man_dok;
    assign mem_rdata   = auto_rdata;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIMIT(4)) dut (
        .clk(clk), .reset(reset),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
        .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
        .data_rdata(data_rdata),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_wstrb(mem_wstrb), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok),
        .mem_rdata(mem_rdata), .busy(busy), .proto_err(proto_err)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic expect_txn(input bit owner, input logic [31:0] rd);
        gq.push_back(owner);
        dq.push_back({owner, rd});
        rq.push_back(rd);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy && n < 100);
        chk(name, 64'(busy), 64'd0);
    endtask

    // Memory responder: addr_ok after addr_dly stalled cycles, data_ok after data_dly more.
    initial begin
        int phase = 0;
        int acnt = 0;
        int dcnt = 0;
        auto_aok = 1'b0;
        auto_dok = 1'b0;
        auto_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            auto_aok = 1'b0;
            auto_dok = 1'b0;
            auto_rdata = '0;
            if (!resp_en || reset) begin
                phase = 0;
                acnt = 0;
                dcnt = 0;
            end else if (phase == 0) begin
                if (mem_req) begin
                    if (acnt >= addr_dly) begin
                        auto_aok = 1'b1;
                        phase = 1;
                        dcnt = 0;
                    end else begin
                        acnt++;
                    end
                end
            end else begin
                if (dcnt >= data_dly) begin
                    auto_dok = 1'b1;
                    if (rq.size() > 0) auto_rdata = rq.pop_front();
                    phase = 0;
                    acnt = 0;
                end else begin
                    dcnt++;
                end
            end
        end
    end

    // Monitor: every grant and every response is matched against the scoreboard queues.
    initial begin
        bit    eg;
        dexp_t ed;
        forever begin
            @(negedge clk);
            if (inst_addr_ok || data_addr_ok) begin
                chk("addr_ok_exclusive", 64'(inst_addr_ok & data_addr_ok), 64'd0);
                if (gq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_grant actual=inst:%0b,data:%0b required=none", inst_addr_ok, data_addr_ok);
                end else begin
                    eg = gq.pop_front();
                    chk("grant_owner", 64'(data_addr_ok), 64'(eg));
                end
            end
            if (inst_data_ok || data_data_ok) begin
                chk("data_ok_exclusive", 64'(inst_data_ok & data_data_ok), 64'd0);
                if (dq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_data_ok actual=inst:%0b,data:%0b required=none", inst_data_ok, data_data_ok);
                end else begin
                    ed = dq.pop_front();
                    chk("rsp_owner", 64'(data_data_ok), 64'(ed.owner));
                    chk("rsp_rdata", 64'(ed.owner ? data_rdata : inst_rdata), 64'(ed.rdata));
                    chk("rsp_other_rdata_zero", 64'(ed.owner ? inst_rdata : data_rdata), 64'd0);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found, seen_ddok;
        int ddok_cnt, gcnt, at;
        reset = 1'b1;
        resp_en = 1'b1;
        man_aok = 1'b0;
        man_dok = 1'b0;
        addr_dly = 0;
        data_dly = 0;
        inst_req = 1'b1;
        inst_addr = 32'h1C00_0000;
        data_req = 1'b1;
        data_wr = 1'b0;
        data_wstrb = 4'h0;
        data_addr = '0;
        data_wdata = '0;

        // Reset state, with both requests asserted
        repeat (2) @(negedge clk);
        chk("rst_mem_req", 64'(mem_req), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_proto_err", 64'(proto_err), 64'd0);
        chk("rst_mem_addr", 64'(mem_addr), 64'd0);
        chk("rst_mem_wr_wstrb_wdata", {27'd0, mem_wr, mem_wstrb, mem_wdata}, 64'd0);
        chk("rst_addr_ok", {62'd0, inst_addr_ok, data_addr_ok}, 64'd0);
        @(posedge clk); #1;
        inst_req = 1'b0;
        data_req = 1'b0;
        reset = 1'b0;

        // T1: single inst read with minimum latency
        @(posedge clk); #1;
        expect_txn(1'b0, 32'h0240_0C04);
        inst_req = 1'b1;
        inst_addr = 32'h1C00_0000;
        @(negedge clk);
        chk("t1_inst_addr_ok_t", 64'(inst_addr_ok), 64'd1);
        @(posedge clk); #1;
        inst_req = 1'b0;
        @(negedge clk);
        chk("t1_mem_req_t1", 64'(mem_req), 64'd1);
        chk("t1_mem_addr", 64'(mem_addr), 64'h1C00_0000);
        chk("t1_mem_wr_wstrb", {59'd0, mem_wr, mem_wstrb}, 64'd0);
        @(negedge clk);
        chk("t1_inst_data_ok_t2", 64'(inst_data_ok), 64'd1);
        chk("t1_inst_rdata_t2", 64'(inst_rdata), 64'h0240_0C04);
        @(negedge clk);
        chk("t1_busy_low_t3", 64'(busy), 64'd0);

        // T2: simultaneous store and inst read, data wins
        @(posedge clk); #1;
        expect_txn(1'b1, 32'h0000_0000);
        expect_txn(1'b0, 32'h1111_1111);
        data_req = 1'b1;
        data_wr = 1'b1;
        data_addr = 32'h0000_0008;
        data_wdata = 32'hDEAD_BEEF;
        data_wstrb = 4'hF;
        inst_req = 1'b1;
        inst_addr = 32'h1C00_0004;
        @(negedge clk);
        chk("t2_data_first", {62'd0, data_addr_ok, inst_addr_ok}, 64'd2);
        @(posedge clk); #1;
        data_req = 1'b0;
        @(negedge clk);
        chk("t2_mem_wr", 64'(mem_wr), 64'd1);
        chk("t2_mem_wstrb", 64'(mem_wstrb), 64'hF);
        chk("t2_mem_wdata", 64'(mem_wdata), 64'hDEAD_BEEF);
        chk("t2_mem_addr", 64'(mem_addr), 64'h8);
        found = 1'b0;
        seen_ddok = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (data_data_ok) seen_ddok = 1'b1;
            if (inst_addr_ok) found = 1'b1;
        end
        chk("t2_inst_granted", 64'(found), 64'd1);
        chk("t2_inst_after_data_ok", 64'(seen_ddok), 64'd1);
        @(posedge clk); #1;
        inst_req = 1'b0;
        wait_idle("t2_idle");

        // T3: address phase stalled for 5 cycles, fields must hold
        @(posedge clk); #1;
        addr_dly = 5;
        expect_txn(1'b1, 32'h0000_0000);
        data_req = 1'b1;
        data_wr = 1'b1;
        data_addr = 32'h0000_0100;
        data_wdata = 32'hCAFE_F00D;
        data_wstrb = 4'h3;
        @(negedge clk);
        chk("t3_grant", 64'(data_addr_ok), 64'd1);
        @(posedge clk); #1;
        data_req = 1'b0;
        data_addr = 32'hFFFF_FFF0;
        data_wdata = 32'h0BAD_0BAD;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t3_stall_mem_req", 64'(mem_req), 64'd1);
            chk("t3_stall_mem_addr", 64'(mem_addr), 64'h100);
            chk("t3_stall_mem_wdata", 64'(mem_wdata), 64'hCAFE_F00D);
            chk("t3_stall_no_data_ok", 64'(data_data_ok), 64'd0);
        end
        wait_idle("t3_idle");
        addr_dly = 0;

        // T4: load with 7-cycle data wait, inst held throughout
        @(posedge clk); #1;
        data_dly = 7;
        expect_txn(1'b1, 32'h55AA_55AA);
        expect_txn(1'b0, 32'h1234_5678);
        data_req = 1'b1;
        data_wr = 1'b0;
        data_wstrb = 4'hF;
        data_addr = 32'h0000_0200;
        inst_req = 1'b1;
        inst_addr = 32'h1C00_0008;
        @(negedge clk);
        chk("t4_grant_data", 64'(data_addr_ok), 64'd1);
        @(posedge clk); #1;
        data_req = 1'b0;
        @(negedge clk);
        chk("t4_load_wr_wstrb", {59'd0, mem_wr, mem_wstrb}, 64'd0);
        chk("t4_load_addr", 64'(mem_addr), 64'h200);
        found = 1'b0;
        ddok_cnt = 0;
        at = 0;
        for (int i = 2; i < 40 && !found; i++) begin
            @(negedge clk);
            if (data_data_ok) ddok_cnt++;
            if (inst_addr_ok) begin
                found = 1'b1;
                at = i;
            end
        end
        chk("t4_data_ok_once", 64'(ddok_cnt), 64'd1);
        chk("t4_inst_grant_cycle", 64'(at), 64'd10);
        @(posedge clk); #1;
        inst_req = 1'b0;
        data_dly = 0;
        wait_idle("t4_idle");

        // T5: reset in WAIT and in REQ, then protocol error detection
        @(posedge clk); #1;
        resp_en = 1'b0;
        gq.push_back(1'b0);
        inst_req = 1'b1;
        inst_addr = 32'h0000_0040;
        @(negedge clk);
        chk("t5_grant", 64'(inst_addr_ok), 64'd1);
        @(posedge clk); #1;
        inst_req = 1'b0;
        man_aok = 1'b1;
        @(posedge clk); #1;
        man_aok = 1'b0;
        @(negedge clk);
        chk("t5_in_wait_busy", 64'(busy), 64'd1);
        chk("t5_in_wait_mem_req", 64'(mem_req), 64'd0);
        #2;
        reset = 1'b1;
        #1;
        chk("t5_rst_busy", 64'(busy), 64'd0);
        chk("t5_rst_mem_addr", 64'(mem_addr), 64'd0);
        man_dok = 1'b1;
        #1;
        chk("t5_rst_no_data_ok", {62'd0, inst_data_ok, data_data_ok}, 64'd0);
        @(posedge clk); #1;
        man_dok = 1'b0;
        reset = 1'b0;
        @(posedge clk); #1;
        gq.push_back(1'b0);
        inst_req = 1'b1;
        inst_addr = 32'h0000_0044;
        @(posedge clk); #1;
        inst_req = 1'b0;
        @(negedge clk);
        chk("t5_req_mem_req", 64'(mem_req), 64'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("t5_async_mem_req_drop", 64'(mem_req), 64'd0);
        chk("t5_async_busy_drop", 64'(busy), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        man_dok = 1'b1;
        @(negedge clk);
        chk("t5_idle_dok_not_forwarded", {62'd0, inst_data_ok, data_data_ok}, 64'd0);
        chk("t5_proto_err_before_edge", 64'(proto_err), 64'd0);
        @(posedge clk); #1;
        man_dok = 1'b0;
        @(negedge clk);
        chk("t5_proto_err_set", 64'(proto_err), 64'd1);
        repeat (3) @(negedge clk);
        chk("t5_proto_err_sticky", 64'(proto_err), 64'd1);
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        chk("t5_proto_err_cleared", 64'(proto_err), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        resp_en = 1'b1;

        // T6: both requesters pending continuously for ten grants
        @(posedge clk); #1;
        for (int k = 0; k < 10; k++) begin
`ifdef ARB_FAIR_EN
            expect_txn((k % 5) != 4, 32'hA000_0000 + 32'(k));
`else
            expect_txn(1'b1, 32'hA000_0000 + 32'(k));
`endif
        end
        data_req = 1'b1;
        data_wr = 1'b0;
        data_addr = 32'h0000_0300;
        inst_req = 1'b1;
        inst_addr = 32'h1C00_0010;
        gcnt = 0;
        for (int i = 0; i < 200 && gcnt < 10; i++) begin
            @(negedge clk);
            if (inst_addr_ok || data_addr_ok) gcnt++;
        end
        chk("t6_grant_count", 64'(gcnt), 64'd10);
        @(posedge clk); #1;
        data_req = 1'b0;
        inst_req = 1'b0;
        wait_idle("t6_idle");

        repeat (3) @(negedge clk);
        chk("grant_queue_drained", 64'(gq.size()), 64'd0);
        chk("rsp_queue_drained", 64'(dq.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one SRAM-like memory port between the instruction-fetch requester (IF stage) and the data requester (MEM stage, which issues load/store for data_ram_r_data).
- Exactly one outstanding transaction at a time.
- Read data returns to the owner via a data_ok pulse.
- Address/data split handshake; wait states on either phase.

Parameters:
- ADDR_W, 32, address width of all three interfaces
- DATA_W, 32, data width; wstrb width is DATA_W/8
- STARVE_LIMIT, 4, consecutive data grants tolerated while inst_req pending (used only with ARB_FAIR_EN)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- inst_req  in  1  IF requests a read
- inst_addr  in  ADDR_W  IF read address
- inst_addr_ok  out  1  IF request accepted this cycle
- inst_data_ok  out  1  IF read data valid this cycle
- inst_rdata  out  DATA_W  IF read data
- data_req  in  1  MEM requests access
- data_wr  in  1  1=store, 0=load
- data_wstrb  in  DATA_W/8  byte enables for store
- data_addr  in  ADDR_W  MEM address
- data_wdata  in  DATA_W  store data
- data_addr_ok  out  1  MEM request accepted this cycle
- data_data_ok  out  1  MEM load data valid / store complete
- data_rdata  out  DATA_W  MEM load data
- mem_req  out  1  request to memory port
- mem_wr  out  1  write flag
- mem_wstrb  out  DATA_W/8  byte enables, 0 on reads
- mem_addr  out  ADDR_W  address
- mem_wdata  out  DATA_W  write data
- mem_addr_ok  in  1  memory accepted address phase
- mem_data_ok  in  1  memory completed data phase
- mem_rdata  in  DATA_W  memory read data
- busy  out  1  transaction in flight (state != IDLE)
- proto_err  out  1  sticky: mem_data_ok seen outside WAIT

Behaviour:
- States: IDLE, REQ, WAIT. Owner register: 0=inst, 1=data.
- Reset (async): state=IDLE, owner=0, mem_req=0, mem_wr=0, mem_wstrb=0, mem_addr=0, mem_wdata=0, proto_err=0, starve count=0.
  - All *_addr_ok and *_data_ok outputs are 0 while in reset.
- IDLE:
  - Grant is combinational. Fixed priority: data_req beats inst_req.
  - Granted requester gets addr_ok=1 in the same cycle.
  - Its addr/wr/wstrb/wdata are latched into the mem_* registers and owner is recorded.
  - Next state is REQ. With no request, stay in IDLE.
  - Inst grants latch wr=0, wstrb=0, wdata=0. Data loads latch wstrb=0.
- REQ:
  - mem_req=1 with latched fields held stable.
  - On mem_addr_ok=1: mem_req drops next cycle, go to WAIT. Otherwise hold.
  - No addr_ok is issued to any requester.
- WAIT:
  - On mem_data_ok=1: owner's data_ok=1 in the same cycle (combinational), go to IDLE.
  - Returned read data equals mem_rdata (combinational pass-through).
  - The non-owner's rdata is 0.
- Minimum latency: grant at cycle t, mem_req at t+1; with mem_addr_ok at t+1, data_ok earliest at t+2; next grant earliest at t+3.
- addr_ok and data_ok are never asserted to both requesters in one cycle.
- Requests held during busy are not acknowledged and must stay asserted.
- mem_data_ok in IDLE or REQ sets proto_err and is not forwarded. proto_err clears only on reset.
- Reset mid-transaction: returns to IDLE immediately and mem_req deasserts asynchronously. The in-flight transaction is abandoned and no data_ok is issued.

Optional Feature:
- Macro ARB_FAIR_EN.
- Defined:
  - A 3-bit saturating counter increments on each data grant made while inst_req=1.
  - It clears on any inst grant.
  - When count==STARVE_LIMIT and both requesters are pending, inst wins.
- Undefined: strict data priority, and no counter is instantiated.

Test Plan:
- Single inst read, addr 0x1C00_0000; mem_addr_ok at t+1, mem_data_ok at t+2 with rdata 0x0240_0C04 -> inst_addr_ok at t, inst_data_ok=1 and inst_rdata=0x0240_0C04 at t+2, busy low at t+3.
- inst_req and data_req (store 0x8, wdata 0xDEAD_BEEF, wstrb 0xF) in the same cycle -> data granted first with mem_wr=1 and mem_wstrb=0xF; inst granted only after data_data_ok.
- mem_addr_ok held low 5 cycles in REQ -> mem_req, mem_addr and mem_wdata stable all 5 cycles; no data_ok.
- Load with mem_data_ok delayed 7 cycles in WAIT -> data_data_ok exactly once; inst_req held throughout gets no addr_ok until IDLE.
- Assert reset while in WAIT, then pulse mem_data_ok -> state IDLE, no data_ok, mem_req=0.
  - Separately, mem_data_ok pulsed in IDLE -> proto_err=1, stays 1 until reset.
- ARB_FAIR_EN, both requesting continuously -> grant sequence D,D,D,D,I,D,D,D,D,I.
  - Without the macro: all grants go to data.
